// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one bit per clock, LSB first, with valid/ready handshakes.
// Optional macro SERIAL_SUBTRACTOR_SAT_EN clamps y to zero when the final borrow is set.
module serial_subtractor #(
  parameter int unsigned WORD_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_WIDTH-1:0] a,
  input  logic [WORD_WIDTH-1:0] b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_WIDTH-1:0] y,
  output logic                  bout
);

  localparam int unsigned CntW = $clog2(WORD_WIDTH + 1);
  localparam logic [CntW-1:0] LastBit = CntW'(WORD_WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                state_q, state_d;
  logic [WORD_WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic                  br_q, br_d;
  logic [CntW-1:0]       cnt_q, cnt_d;

  logic                  a_bit, b_bit, diff_bit, br_next;
  logic [WORD_WIDTH:0]   res_shift;

  assign a_bit     = a_q[0];
  assign b_bit     = b_q[0];
  assign diff_bit  = a_bit ^ b_bit ^ br_q;
  assign br_next   = (~a_bit & b_bit) | (~a_bit & br_q) | (b_bit & br_q);
  // New bit enters at the MSB; slicing the widened vector also works for WORD_WIDTH=1.
  assign res_shift = {diff_bit, res_q};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          res_d   = '0;
          br_d    = 1'b0;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        res_d = res_shift[WORD_WIDTH:1];
        br_d  = br_next;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == LastBit) state_d = StDone;
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    y         = '0;
    bout      = 1'b0;
    if (state_q == StDone) begin
      bout = br_q;
`ifdef SERIAL_SUBTRACTOR_SAT_EN
      y    = br_q ? '0 : res_q;
`else
      y    = res_q;
`endif
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WORD_WIDTH=8): directed cases plus random operands
// compared against an arithmetic reference model.
module tb_serial_subtractor;

  localparam int unsigned W = 8;

  logic         clk;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] y;
  logic         bout;

  int checks;
  int failures;

  serial_subtractor #(.WORD_WIDTH(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .bout      (bout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain unsigned arithmetic.
  function automatic logic [W-1:0] model_y(input logic [W-1:0] ma, input logic [W-1:0] mb);
    logic [W-1:0] r;
    r = ma - mb;
`ifdef SERIAL_SUBTRACTOR_SAT_EN
    if (ma < mb) r = '0;
`endif
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one operation, wait for the result, hold it for 'hold' cycles, then consume it.
  task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input int hold,
                        input bit scramble, input string tag);
    int lat;
    logic [W-1:0] ey;
    logic         eb;
    ey = model_y(oa, ob);
    eb = (oa < ob);
    check({tag, ".in_ready_before"}, 32'(in_ready), 32'd1);
    a         = oa;
    b         = ob;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      if (scramble) begin
        a        = W'($urandom);
        b        = W'($urandom);
        in_valid = 1'($urandom);
      end
      if (y !== '0 || in_ready !== 1'b0) begin
        check({tag, ".busy_outputs"}, {23'd0, in_ready, y}, 32'd0);
      end
      tick();
      lat++;
    end
    in_valid = 1'b0;
    check({tag, ".latency"}, 32'(lat), 32'(W));
    check({tag, ".y"}, 32'(y), 32'(ey));
    check({tag, ".bout"}, 32'(bout), 32'(eb));
    check({tag, ".in_ready_done"}, 32'(in_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, ".hold"}, {22'd0, out_valid, in_ready, y}, {22'd0, 1'b1, 1'b0, ey});
      check({tag, ".hold_bout"}, 32'(bout), 32'(eb));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, ".after_consume"}, {22'd0, in_ready, out_valid, y}, {22'd0, 1'b1, 1'b0, 8'h00});
    check({tag, ".bout_idle"}, 32'(bout), 32'd0);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    checks    = 0;
    failures  = 0;
    reset_n   = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    #3 reset_n = 1'b0;
    #1;
    check("reset_during", {22'd0, in_ready, out_valid, y}, {22'd0, 1'b1, 1'b0, 8'h00});
    check("reset_during_bout", 32'(bout), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    tick();
    check("reset_after", {22'd0, in_ready, out_valid, y}, {22'd0, 1'b1, 1'b0, 8'h00});

    run_op(8'h05, 8'h03, 0, 1'b0, "basic");
    run_op(8'h03, 8'h05, 0, 1'b0, "borrow");
    run_op(8'hAA, 8'hAA, 0, 1'b1, "equal_scramble");
    run_op(8'h00, 8'hFF, 5, 1'b0, "hold5");

    // Abort in RUN after four processed bits.
    check("abort.in_ready_before", 32'(in_ready), 32'd1);
    a        = 8'h5C;
    b        = 8'h3A;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    check("abort.running", {30'd0, in_ready, out_valid}, 32'd0);
    #2 reset_n = 1'b0;
    #1;
    check("abort.outputs", {22'd0, in_ready, out_valid, y}, {22'd0, 1'b1, 1'b0, 8'h00});
    check("abort.bout", 32'(bout), 32'd0);
    tick();
    reset_n = 1'b1;
    repeat (12) begin
      tick();
      check("abort.no_result", 32'(out_valid), 32'd0);
    end
    run_op(8'h80, 8'h01, 0, 1'b0, "post_reset");

    for (int i = 0; i < 8; i++) begin
      ra = W'($urandom);
      rb = (i % 3 == 0) ? ra : W'($urandom);
      run_op(ra, rb, int'($urandom_range(0, 3)), 1'($urandom), "random");
    end
    run_op(8'h00, 8'h00, 0, 1'b0, "zero");
    run_op(8'hFF, 8'h00, 1, 1'b0, "max_minus_zero");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have parameter WORD_WIDTH, default 8, giving the operand/result width in bits (legal range 1..32).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: operands a/b valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: block can accept operands.
REQ-006 The block SHALL have ports a and b, input, WORD_WIDTH bits each: unsigned minuend and subtrahend.
REQ-007 The block SHALL have port out_valid, output, 1 bit: result valid.
REQ-008 The block SHALL have port out_ready, input, 1 bit: consumer accepts result.
REQ-009 The block SHALL have port y, output, WORD_WIDTH bits: difference.
REQ-010 The block SHALL have port bout, output, 1 bit: final borrow (1 iff a < b, unsigned).

Function
REQ-011 The block SHALL implement three states: IDLE, RUN and DONE.
REQ-012 in_ready SHALL be 1 exactly when the state is IDLE; out_valid SHALL be 1 exactly when the state is DONE.
REQ-013 On a rising edge with in_ready and in_valid both 1, the block SHALL capture a and b into shift registers, clear the borrow flop and the bit counter, and enter RUN.
REQ-014 a and b SHALL be sampled only at the accepting edge; changes to in_valid, a or b afterwards SHALL have no effect.
REQ-015 In RUN, each edge SHALL process one bit, LSB first: d = a_i ^ b_i ^ br; br_next = (~a_i & b_i) | (~a_i & br) | (b_i & br); d shifts into the result register MSB and the counter increments.
REQ-016 After exactly WORD_WIDTH RUN edges, the block SHALL enter DONE, so out_valid is first high WORD_WIDTH cycles after the accepting edge.
REQ-017 In DONE, y SHALL equal (a - b) mod 2^WORD_WIDTH and bout SHALL equal the final borrow.
REQ-018 y and bout SHALL hold stable while out_valid=1 and out_ready=0, with no timeout.
REQ-019 On an edge in DONE with out_ready=1, the block SHALL return to IDLE; in that same edge the block SHALL not accept new operands (in_ready is 0 in DONE).
REQ-020 Outside DONE, y and bout SHALL read 0.
REQ-021 For WORD_WIDTH=1, the block SHALL reach DONE after one RUN edge.

Reset
REQ-022 While reset_n=0, regardless of the clock, the state SHALL be IDLE, and the shift registers, borrow flop and counter SHALL be 0.
REQ-023 During and immediately after reset, outputs SHALL be in_ready=1, out_valid=0, y=0 and bout=0.
REQ-024 Reset asserted in RUN or DONE SHALL abandon the operation with no result emitted.

Configuration
REQ-025 The block SHALL provide a macro SERIAL_SUBTRACTOR_SAT_EN.
- Defined: when the final borrow is 1, y in DONE SHALL be forced to 0 (unsigned saturation), and bout still reports 1.
- Undefined: y SHALL be the wrapped modulo difference.

Verification (WORD_WIDTH=8)
REQ-026 The bench SHALL cover: a=8'h05, b=8'h03, out_ready=1 -> out_valid high 8 cycles after accept, y=8'h02, bout=0, then in_ready=1 on the next cycle.
REQ-027 The bench SHALL cover: a=8'h03, b=8'h05 -> bout=1; y=8'hFE without the macro, y=8'h00 with SERIAL_SUBTRACTOR_SAT_EN.
REQ-028 The bench SHALL cover: a=b=8'hAA, with a and b driven to random values during RUN -> y=8'h00, bout=0 (inputs ignored after accept).
REQ-029 The bench SHALL cover: a=8'h00, b=8'hFF, out_ready=0 for 5 cycles in DONE -> y=8'h01, bout=1 held for all 5 cycles, in_ready=0, and IDLE reached on the first edge with out_ready=1.
REQ-030 The bench SHALL cover: reset_n pulsed low at RUN count 4 -> outputs immediately become in_ready=1, out_valid=0, y=0; a following op a=8'h80, b=8'h01 -> y=8'h7F, bout=0.
